// File: rtl/apb_bridge_nslave_if.sv
// Request/response and APB bus bundle for apb_bridge_nslave.
// master: the bridge side (drives APB, answers requests).
// slave : the requester plus peripherals side.
interface apb_bridge_nslave_if #(
  parameter int NSLV = 4,
  parameter int AW   = 10,
  parameter int DW   = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [AW-1:0]        req_addr;
  logic [DW-1:0]        req_wdata;
  logic                 rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;
  logic [NSLV-1:0]      PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [AW-1:0]        PADDR;
  logic [DW-1:0]        PWDATA;
  logic [NSLV*DW-1:0]   PRDATA;
  logic [NSLV-1:0]      PREADY;
  logic [NSLV-1:0]      PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_bridge_nslave.sv
// APB master bridge: valid/ready request port -> APB SETUP/ACCESS transfers,
// address-decoded across NSLV slaves; unmapped addresses return a bus error.
// Optional ACCESS watchdog enabled by defining the macro APB_TIMEOUT_EN.
module apb_bridge_nslave #(
  parameter int NSLV    = 4,
  parameter int AW      = 10,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_bridge_nslave_if.master  bus
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [SW:0] NSLV_V = (SW+1)'(NSLV);

  if (NSLV < 1 || NSLV > 16) begin : g_bad_nslv
    $error("apb_bridge_nslave: NSLV must be 1..16");
  end
  if (AW <= SW) begin : g_bad_aw
    $error("apb_bridge_nslave: AW must exceed the select width");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("apb_bridge_nslave: TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            pwrite_q;
  logic [AW-1:0]   paddr_q;
  logic [DW-1:0]   pwdata_q;
  logic [SW-1:0]   sel;
  logic            mapped;
  logic            sel_ready;
  logic            sel_err;
  logic [DW-1:0]   sel_rdata;
  logic            tmo_hit;
  logic            done;

  assign sel    = paddr_q[AW-1 -: SW];
  assign mapped = ({1'b0, sel} < NSLV_V);

  // Mux the selected slave's response; unmapped selects match no slave.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel == SW'(i)) begin
        sel_ready = bus.PREADY[i];
        sel_err   = bus.PSLVERR[i];
        sel_rdata = bus.PRDATA[i*DW +: DW];
      end
    end
  end

  assign done = (state_q == ACCESS) && (!mapped || sel_ready || tmo_hit);

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] acc_cnt;

  // Count ACCESS cycles of the current transfer; restart on each SETUP entry.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      acc_cnt <= '0;
    else if (state_d == SETUP)
      acc_cnt <= '0;
    else if (state_q == ACCESS)
      acc_cnt <= acc_cnt + CW'(1);
  end

  assign tmo_hit = (state_q == ACCESS) && (acc_cnt == CW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake ready, APB phase and one-hot select.
  always_comb begin
    bus.req_ready = (state_q == IDLE) && !PRESET;
    bus.PENABLE   = (state_q == ACCESS);
    bus.PSEL      = '0;
    if (state_q != IDLE) begin
      for (int i = 0; i < NSLV; i++) begin
        if (sel == SW'(i)) bus.PSEL[i] = 1'b1;
      end
    end
  end

  // Latch the accepted request; held through the transfer and while idle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (state_q == IDLE && bus.req_valid) begin
      pwrite_q <= bus.req_write;
      paddr_q  <= bus.req_addr;
      pwdata_q <= bus.req_wdata;
    end
  end

  assign bus.PWRITE = pwrite_q;
  assign bus.PADDR  = paddr_q;
  assign bus.PWDATA = pwdata_q;

  // Register the completion: one-cycle valid pulse, sticky result fields.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else if (done) begin
      bus.rsp_valid   <= 1'b1;
      bus.rsp_err     <= !mapped || (sel_ready ? sel_err : 1'b1);
      bus.rsp_timeout <= mapped && !sel_ready && tmo_hit;
      bus.rsp_rdata   <= (mapped && sel_ready && !sel_err && !pwrite_q) ? sel_rdata : '0;
    end else begin
      bus.rsp_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_bridge_nslave.sv
// Directed bench for apb_bridge_nslave: a 4-slave instance for the main
// traffic and a 3-slave instance for the unmapped-address case.
module tb_apb_bridge_nslave;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 PCLK = ~PCLK;

  apb_bridge_nslave_if #(.NSLV(4), .AW(10), .DW(8)) bus ();
  apb_bridge_nslave_if #(.NSLV(3), .AW(10), .DW(8)) bus3 ();

  apb_bridge_nslave #(.NSLV(4), .AW(10), .DW(8), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus.master)
  );

  apb_bridge_nslave #(.NSLV(3), .AW(10), .DW(8), .TIMEOUT(4)) dut3 (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus3.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One transfer on the 4-slave instance. The selected slave's PREADY stays
  // low for 'waits' ACCESS cycles while the other slaves show ready.
  task automatic xfer(input string tag, input logic wr, input logic [9:0] addr,
                      input logic [7:0] wd, input int slv, input int waits,
                      input logic [7:0] exp_rdata, input logic exp_err,
                      input logic exp_to, input int exp_acc);
    int acc;
    logic [3:0] onehot;
    onehot = 4'b0001 << slv;
    @(negedge PCLK);
    check({tag, ".ready_idle"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.PREADY    = 4'b0000;
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    check({tag, ".setup_psel"}, bus.PSEL, onehot);
    check({tag, ".setup_penable"}, bus.PENABLE, 0);
    check({tag, ".setup_ready"}, bus.req_ready, 0);
    check({tag, ".paddr"}, bus.PADDR, addr);
    check({tag, ".pwrite"}, bus.PWRITE, wr);
    check({tag, ".pwdata"}, bus.PWDATA, wd);
    @(negedge PCLK);
    acc = 0;
    for (int c = 0; c < 40 && bus.PENABLE; c++) begin
      acc++;
      check({tag, ".access_psel"}, bus.PSEL, onehot);
      check({tag, ".access_rsp_valid"}, bus.rsp_valid, 0);
      bus.PREADY = (acc > waits) ? onehot : ~onehot;
      @(negedge PCLK);
    end
    bus.PREADY = 4'b0000;
    check({tag, ".access_cycles"}, acc, exp_acc);
    check({tag, ".rsp_valid"}, bus.rsp_valid, 1);
    check({tag, ".rsp_err"}, bus.rsp_err, exp_err);
    check({tag, ".rsp_timeout"}, bus.rsp_timeout, exp_to);
    check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, ".rsp_ready"}, bus.req_ready, 1);
    check({tag, ".rsp_psel"}, bus.PSEL, 0);
    @(negedge PCLK);
    check({tag, ".rsp_pulse"}, bus.rsp_valid, 0);
    check({tag, ".rdata_hold"}, bus.rsp_rdata, exp_rdata);
    check({tag, ".err_hold"}, bus.rsp_err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR = '0;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0;
    bus3.PRDATA = '0; bus3.PREADY = '0; bus3.PSLVERR = '0;

    // Reset state
    repeat (2) @(negedge PCLK);
    check("rst.psel", bus.PSEL, 0);
    check("rst.penable", bus.PENABLE, 0);
    check("rst.paddr", bus.PADDR, 0);
    check("rst.pwdata", bus.PWDATA, 0);
    check("rst.rsp_valid", bus.rsp_valid, 0);
    check("rst.rsp_rdata", bus.rsp_rdata, 0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("rst.ready_after", bus.req_ready, 1);

    // Write 0xA5 to slave 1, zero wait states; read data must not leak
    bus.PRDATA = 32'hDEADBEEF;
    xfer("wr_s1", 1'b1, 10'h105, 8'hA5, 1, 0, 8'h00, 1'b0, 1'b0, 1);

    // Read slave 2 with PSLVERR: error, data forced to 0
    bus.PRDATA  = 32'h00FF0000;
    bus.PSLVERR = 4'b0100;
    xfer("rd_s2_err", 1'b0, 10'h200, 8'h00, 2, 0, 8'h00, 1'b1, 1'b0, 1);
    bus.PSLVERR = 4'b0000;

`ifdef APB_TIMEOUT_EN
    // Watchdog: PREADY never comes, 4 ACCESS cycles then timeout error
    bus.PRDATA = 32'h77777777;
    xfer("tmo_fire", 1'b0, 10'h0C8, 8'h00, 0, 100, 8'h00, 1'b1, 1'b1, 4);
    // PREADY arrives in the 4th ACCESS cycle: normal completion wins
    xfer("tmo_race", 1'b0, 10'h0C8, 8'h00, 0, 3, 8'h77, 1'b0, 1'b0, 4);
`endif

    // Read slave 3 with 3 wait states
    bus.PRDATA = 32'h5C112233;
    xfer("rd_s3_wait", 1'b0, 10'h3F0, 8'h00, 3, 3, 8'h5C, 1'b0, 1'b0, 4);

    // Unmapped address on the 3-slave instance
    @(negedge PCLK);
    check("unmap.ready", bus3.req_ready, 1);
    bus3.req_valid = 1'b1;
    bus3.req_addr  = 10'h3F0;
    bus3.PRDATA    = 24'hABCDEF;
    @(negedge PCLK);
    bus3.req_valid = 1'b0;
    check("unmap.setup_psel", bus3.PSEL, 0);
    check("unmap.setup_penable", bus3.PENABLE, 0);
    @(negedge PCLK);
    check("unmap.access_psel", bus3.PSEL, 0);
    check("unmap.access_penable", bus3.PENABLE, 1);
    @(negedge PCLK);
    check("unmap.rsp_valid", bus3.rsp_valid, 1);
    check("unmap.rsp_err", bus3.rsp_err, 1);
    check("unmap.rsp_rdata", bus3.rsp_rdata, 0);
    @(negedge PCLK);
    check("unmap.pulse", bus3.rsp_valid, 0);

    // Reset in the middle of a read's ACCESS phase
    @(negedge PCLK);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 10'h3C4;
    bus.req_wdata = 8'h3C;
    bus.PREADY    = 4'b0000;
    @(negedge PCLK);
    bus.req_valid = 1'b0;
    @(negedge PCLK);
    check("abort.in_access", bus.PENABLE, 1);
    PRESET = 1'b1;
    #1;
    check("abort.psel", bus.PSEL, 0);
    check("abort.penable", bus.PENABLE, 0);
    check("abort.paddr", bus.PADDR, 0);
    check("abort.pwrite", bus.PWRITE, 0);
    check("abort.pwdata", bus.PWDATA, 0);
    check("abort.rsp_rdata", bus.rsp_rdata, 0);
    check("abort.rsp_err", bus.rsp_err, 0);
    check("abort.rsp_valid", bus.rsp_valid, 0);
    check("abort.req_ready", bus.req_ready, 0);
    @(negedge PCLK);
    bus.PREADY = 4'b1111;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("abort.no_rsp", bus.rsp_valid, 0);
    check("abort.idle", bus.PENABLE, 0);
    bus.PREADY = 4'b0000;

    // Normal transfer after the aborted one
    bus.PRDATA = 32'h00004200;
    xfer("post_rst", 1'b0, 10'h140, 8'h00, 1, 1, 8'h42, 1'b0, 1'b0, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
